nic_ctrl_csr: RTL and testbench

- Avalon-MM slave that owns the network-stack configuration set: host MAC, alternate MAC, alt-MAC enable, promiscuous mode, CPU encapsulation VLAN and MTU.
- CPU writes go to shadow registers. A commit request copies all shadows to the active outputs in one cycle, only while the RX datapath reports a frame boundary (idle).
- Outputs drive the csr side of the NIC control interface, so classification logic never sees a half-updated configuration.

---
 rtl/nic_ctrl_csr.sv | 250 +++++++++++++++++++++++++
 tb/tb_nic_ctrl_csr.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_ctrl_csr.sv
// NIC configuration CSRs: CPU-written shadow set, copied atomically to the active outputs on commit at an RX frame boundary.
// Optional: define NIC_CTRL_CSR_COMMIT_TIMEOUT_EN to force the commit after COMMIT_TIMEOUT cycles without idle.
module nic_ctrl_csr #(
  parameter logic [47:0] DEF_HOST_MAC   = 48'h0,
  parameter logic [15:0] DEF_MTU        = 16'd1500,
  parameter logic [15:0] MTU_MIN        = 16'd68,
  parameter logic [15:0] MTU_MAX        = 16'd9600,
  parameter int unsigned COMMIT_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  avs_address_i,
  input  logic        avs_write_i,
  input  logic [31:0] avs_writedata_i,
  input  logic [3:0]  avs_byteenable_i,
  input  logic        avs_read_i,
  output logic [31:0] avs_readdata_o,
  output logic        avs_readdatavalid_o,
  input  logic        rx_idle_i,
  output logic [47:0] host_mac_o,
  output logic [47:0] alt_host_mac_o,
  output logic        also_use_alt_host_mac_o,
  output logic        promisc_mode_o,
  output logic [11:0] encaps_vlan_o,
  output logic [15:0] mtu_o,
  output logic        cfg_update_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [47:0] mac_sh_q, mac_sh_d, alt_sh_q, alt_sh_d;
  logic [11:0] vlan_sh_q, vlan_sh_d;
  logic [15:0] mtu_sh_q, mtu_sh_d;
  logic        promisc_sh_q, promisc_sh_d, alt_en_sh_q, alt_en_sh_d;
  logic [47:0] host_mac_q, host_mac_d, alt_mac_q, alt_mac_d;
  logic [11:0] vlan_q, vlan_d;
  logic [15:0] mtu_q, mtu_d;
  logic        promisc_q, promisc_d, alt_en_q, alt_en_d;
  logic        mtu_err_q, mtu_err_d, forced_q, forced_d;
  logic        cfg_update_q, cfg_update_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] reg_val_s, merged_s;
  logic        commit_s, forced_rd_s;

`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(COMMIT_TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  assign forced_rd_s = forced_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^COMMIT_TIMEOUT;
  assign forced_rd_s      = 1'b0;
`endif

  // Register view of the addressed word; also the base for byteenable merges, so unimplemented bits stay 0.
  always_comb begin
    reg_val_s = 32'h0;
    case (avs_address_i)
      3'd0:    reg_val_s = mac_sh_q[31:0];
      3'd1:    reg_val_s = {16'h0, mac_sh_q[47:32]};
      3'd2:    reg_val_s = alt_sh_q[31:0];
      3'd3:    reg_val_s = {16'h0, alt_sh_q[47:32]};
      3'd4:    reg_val_s = {20'h0, vlan_sh_q};
      3'd5:    reg_val_s = {16'h0, mtu_sh_q};
      3'd6:    reg_val_s = {30'h0, alt_en_sh_q, promisc_sh_q};
      3'd7:    reg_val_s = {29'h0, mtu_err_q, forced_rd_s, (state_q != ST_IDLE)};
      default: reg_val_s = 32'h0;
    endcase
    merged_s = be_merge(reg_val_s, avs_writedata_i, avs_byteenable_i);
    commit_s = avs_write_i && (avs_address_i == 3'd7) && avs_byteenable_i[0] && avs_writedata_i[0];
  end

  // Next-state logic: bus writes into shadows/status, then the commit FSM.
  always_comb begin
    state_d      = state_q;
    mac_sh_d     = mac_sh_q;
    alt_sh_d     = alt_sh_q;
    vlan_sh_d    = vlan_sh_q;
    mtu_sh_d     = mtu_sh_q;
    promisc_sh_d = promisc_sh_q;
    alt_en_sh_d  = alt_en_sh_q;
    host_mac_d   = host_mac_q;
    alt_mac_d    = alt_mac_q;
    vlan_d       = vlan_q;
    mtu_d        = mtu_q;
    promisc_d    = promisc_q;
    alt_en_d     = alt_en_q;
    mtu_err_d    = mtu_err_q;
    forced_d     = forced_q;
    cfg_update_d = 1'b0;
    readdata_d   = avs_read_i ? reg_val_s : 32'h0;
    rvalid_d     = avs_read_i;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    if (avs_write_i) begin
      case (avs_address_i)
        3'd0: mac_sh_d[31:0]  = merged_s;
        3'd1: mac_sh_d[47:32] = merged_s[15:0];
        3'd2: alt_sh_d[31:0]  = merged_s;
        3'd3: alt_sh_d[47:32] = merged_s[15:0];
        3'd4: vlan_sh_d       = merged_s[11:0];
        3'd5: begin
          if ((merged_s[15:0] >= MTU_MIN) && (merged_s[15:0] <= MTU_MAX)) begin
            mtu_sh_d = merged_s[15:0];
          end else begin
            mtu_err_d = 1'b1;
          end
        end
        3'd6: begin
          promisc_sh_d = merged_s[0];
          alt_en_sh_d  = merged_s[1];
        end
        3'd7: begin
          if (avs_byteenable_i[0] && avs_writedata_i[1]) forced_d = 1'b0;
          else forced_d = forced_d;
          if (avs_byteenable_i[0] && avs_writedata_i[2]) mtu_err_d = 1'b0;
          else mtu_err_d = mtu_err_d;
        end
        default: mac_sh_d = mac_sh_q;
      endcase
    end else begin
      mac_sh_d = mac_sh_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_s) begin
          state_d = ST_PEND;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (rx_idle_i) begin
          state_d = ST_APPLY;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
        end else if (cnt_q == TMO_LAST) begin
          state_d  = ST_APPLY;
          forced_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
`else
        end else begin
          state_d = ST_PEND;
`endif
        end
      end
      ST_APPLY: begin
        // Actives take the shadows as registered at the start of APPLY; writes sampled now miss this apply.
        host_mac_d   = mac_sh_q;
        alt_mac_d    = alt_sh_q;
        vlan_d       = vlan_sh_q;
        mtu_d        = mtu_sh_q;
        promisc_d    = promisc_sh_q;
        alt_en_d     = alt_en_sh_q;
        cfg_update_d = 1'b1;
        if (commit_s) begin
          state_d = ST_PEND;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shadow, active and bus-response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mac_sh_q     <= DEF_HOST_MAC;
      alt_sh_q     <= 48'h0;
      vlan_sh_q    <= 12'h0;
      mtu_sh_q     <= DEF_MTU;
      promisc_sh_q <= 1'b0;
      alt_en_sh_q  <= 1'b0;
      host_mac_q   <= DEF_HOST_MAC;
      alt_mac_q    <= 48'h0;
      vlan_q       <= 12'h0;
      mtu_q        <= DEF_MTU;
      promisc_q    <= 1'b0;
      alt_en_q     <= 1'b0;
      mtu_err_q    <= 1'b0;
      forced_q     <= 1'b0;
      cfg_update_q <= 1'b0;
      readdata_q   <= 32'h0;
      rvalid_q     <= 1'b0;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      mac_sh_q     <= mac_sh_d;
      alt_sh_q     <= alt_sh_d;
      vlan_sh_q    <= vlan_sh_d;
      mtu_sh_q     <= mtu_sh_d;
      promisc_sh_q <= promisc_sh_d;
      alt_en_sh_q  <= alt_en_sh_d;
      host_mac_q   <= host_mac_d;
      alt_mac_q    <= alt_mac_d;
      vlan_q       <= vlan_d;
      mtu_q        <= mtu_d;
      promisc_q    <= promisc_d;
      alt_en_q     <= alt_en_d;
      mtu_err_q    <= mtu_err_d;
      forced_q     <= forced_d;
      cfg_update_q <= cfg_update_d;
      readdata_q   <= readdata_d;
      rvalid_q     <= rvalid_d;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign avs_readdata_o          = readdata_q;
  assign avs_readdatavalid_o     = rvalid_q;
  assign host_mac_o              = host_mac_q;
  assign alt_host_mac_o          = alt_mac_q;
  assign also_use_alt_host_mac_o = alt_en_q;
  assign promisc_mode_o          = promisc_q;
  assign encaps_vlan_o           = vlan_q;
  assign mtu_o                   = mtu_q;
  assign cfg_update_o            = cfg_update_q;

endmodule

// File: tb/tb_nic_ctrl_csr.sv
// Directed plus randomized bench for nic_ctrl_csr against a field-level model of the CSR set.
module tb_nic_ctrl_csr;
  localparam int TMO = 16;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
  localparam int HOLD = 10;
`else
  localparam int HOLD = 100;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  avs_address_i;
  logic        avs_write_i;
  logic [31:0] avs_writedata_i;
  logic [3:0]  avs_byteenable_i;
  logic        avs_read_i;
  logic [31:0] avs_readdata_o;
  logic        avs_readdatavalid_o;
  logic        rx_idle_i;
  logic [47:0] host_mac_o, alt_host_mac_o;
  logic        also_use_alt_host_mac_o, promisc_mode_o;
  logic [11:0] encaps_vlan_o;
  logic [15:0] mtu_o;
  logic        cfg_update_o;

  nic_ctrl_csr #(.COMMIT_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .avs_address_i(avs_address_i), .avs_write_i(avs_write_i),
    .avs_writedata_i(avs_writedata_i), .avs_byteenable_i(avs_byteenable_i),
    .avs_read_i(avs_read_i), .avs_readdata_o(avs_readdata_o),
    .avs_readdatavalid_o(avs_readdatavalid_o), .rx_idle_i(rx_idle_i),
    .host_mac_o(host_mac_o), .alt_host_mac_o(alt_host_mac_o),
    .also_use_alt_host_mac_o(also_use_alt_host_mac_o), .promisc_mode_o(promisc_mode_o),
    .encaps_vlan_o(encaps_vlan_o), .mtu_o(mtu_o), .cfg_update_o(cfg_update_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  always @(posedge clk_i) if (cfg_update_o) n_pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: shadow (m_*) and active (a_*) configuration fields.
  logic [47:0] m_mac, m_alt, a_mac, a_alt;
  logic [11:0] m_vlan, a_vlan;
  logic [15:0] m_mtu, a_mtu;
  logic        m_promisc, m_alt_en, a_promisc, a_alt_en, m_err;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mac[31:0];
      3'd1:    return {16'h0, m_mac[47:32]};
      3'd2:    return m_alt[31:0];
      3'd3:    return {16'h0, m_alt[47:32]};
      3'd4:    return {20'h0, m_vlan};
      3'd5:    return {16'h0, m_mtu};
      3'd6:    return {30'h0, m_alt_en, m_promisc};
      default: return {29'h0, m_err, 2'b00};
    endcase
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask, nw;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    nw   = (model_read(a) & ~mask) | (d & mask);
    case (a)
      3'd0: m_mac[31:0]  = nw;
      3'd1: m_mac[47:32] = nw[15:0];
      3'd2: m_alt[31:0]  = nw;
      3'd3: m_alt[47:32] = nw[15:0];
      3'd4: m_vlan       = nw[11:0];
      3'd5: if (nw[15:0] >= 16'd68 && nw[15:0] <= 16'd9600) m_mtu = nw[15:0]; else m_err = 1'b1;
      3'd6: begin m_promisc = nw[0]; m_alt_en = nw[1]; end
      default: if (be[0] && d[2]) m_err = 1'b0;
    endcase
  endfunction

  function automatic void model_apply();
    a_mac = m_mac; a_alt = m_alt; a_vlan = m_vlan; a_mtu = m_mtu;
    a_promisc = m_promisc; a_alt_en = m_alt_en;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_actives(input string tag);
    check({tag, ".host_mac"}, host_mac_o, a_mac);
    check({tag, ".alt_mac"}, alt_host_mac_o, a_alt);
    check({tag, ".vlan"}, encaps_vlan_o, a_vlan);
    check({tag, ".mtu"}, mtu_o, a_mtu);
    check({tag, ".promisc"}, promisc_mode_o, a_promisc);
    check({tag, ".alt_en"}, also_use_alt_host_mac_o, a_alt_en);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus(input logic [2:0] a, input logic do_wr, input logic [31:0] d,
                     input logic [3:0] be, input logic do_rd,
                     output logic [31:0] rdata, output logic rvalid);
    avs_address_i = a; avs_write_i = do_wr; avs_writedata_i = d;
    avs_byteenable_i = be; avs_read_i = do_rd;
    tick();
    avs_write_i = 1'b0; avs_read_i = 1'b0;
    rdata = avs_readdata_o; rvalid = avs_readdatavalid_o;
    if (do_wr) model_write(a, d, be);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r; logic v;
    bus(a, 1'b1, d, be, 1'b0, r, v);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r; logic v;
    bus(a, 1'b0, 32'h0, 4'h0, 1'b1, r, v);
    check({tag, ".valid"}, v, 1'b1);
    check(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r, exp32, d;
    logic        v, seen;
    logic [2:0]  a;
    logic [3:0]  be;
    int          base;

    rst_i = 1'b1; avs_address_i = 3'd0; avs_write_i = 1'b0; avs_writedata_i = 32'h0;
    avs_byteenable_i = 4'h0; avs_read_i = 1'b0; rx_idle_i = 1'b0;
    m_mac = 48'h0; m_alt = 48'h0; m_vlan = 12'h0; m_mtu = 16'd1500;
    m_promisc = 1'b0; m_alt_en = 1'b0; m_err = 1'b0;
    model_apply();
    repeat (3) tick();
    rst_i = 1'b0;

    // Reset state.
    check_actives("reset");
    check("reset.cfg_update", cfg_update_o, 1'b0);
    check("reset.rvalid", avs_readdatavalid_o, 1'b0);
    check("reset.rdata", avs_readdata_o, 32'h0);
    repeat (5) tick();
    rd_chk("reset.status", 3'd7, 32'h0);
    rd_chk("reset.mtu_rd", 3'd5, 32'd1500);
    check("reset.no_pulse", n_pulses, 0);

    // Host MAC commit with rx idle.
    rx_idle_i = 1'b1;
    wr(3'd0, 32'h33445566, 4'hf);
    wr(3'd1, 32'h00001122, 4'h3);
    wr(3'd7, 32'h1, 4'h1);
    rd_chk("mac.pending", 3'd7, 32'h1);
    check("mac.pre_cfg", cfg_update_o, 1'b0);
    check("mac.pre_mac", host_mac_o, 48'h0);
    tick();
    check("mac.cfg", cfg_update_o, 1'b1);
    check("mac.host_mac", host_mac_o, 48'h112233445566);
    model_apply();
    rd_chk("mac.pending_clr", 3'd7, 32'h0);
    check("mac.cfg_off", cfg_update_o, 1'b0);
    check("mac.one_pulse", n_pulses, 1);

    // MTU commit held off by a busy RX datapath.
    rx_idle_i = 1'b0;
    wr(3'd5, 32'd9000, 4'hf);
    wr(3'd7, 32'h1, 4'h1);
    for (int i = 0; i < HOLD; i++) begin
      tick();
      check("mtu.hold", mtu_o, 16'd1500);
    end
    rx_idle_i = 1'b1;
    tick();
    check("mtu.apply_cycle", mtu_o, 16'd1500);
    tick();
    check("mtu.applied", mtu_o, 16'd9000);
    check("mtu.cfg", cfg_update_o, 1'b1);
    model_apply();

    // MTU range checks, byteenable merge and W1C of mtu_err.
    wr(3'd5, 32'd100, 4'hf);
    wr(3'd5, 32'd10000, 4'hf);
    rd_chk("mtuerr.shadow_hi", 3'd5, 32'd100);
    rd_chk("mtuerr.status_hi", 3'd7, 32'h4);
    wr(3'd5, 32'd40, 4'b0001);
    rd_chk("mtuerr.shadow_lo", 3'd5, 32'd100);
    rd_chk("mtuerr.status_lo", 3'd7, 32'h4);
    wr(3'd7, 32'h4, 4'hf);
    rd_chk("mtuerr.cleared", 3'd7, 32'h0);
    check("mtuerr.model", m_err, 1'b0);

    // No idle: forced commit after the timeout, or indefinite wait.
    rx_idle_i = 1'b0;
    wr(3'd4, 32'h00000abc, 4'hf);
    wr(3'd7, 32'h1, 4'h1);
    base = n_pulses;
`ifdef NIC_CTRL_CSR_COMMIT_TIMEOUT_EN
    repeat (TMO) tick();
    check("tmo.pre_vlan", encaps_vlan_o, a_vlan);
    check("tmo.pre_cfg", cfg_update_o, 1'b0);
    tick();
    model_apply();
    check("tmo.cfg", cfg_update_o, 1'b1);
    check("tmo.vlan", encaps_vlan_o, 12'habc);
    rd_chk("tmo.forced", 3'd7, 32'h2);
    wr(3'd7, 32'h2, 4'h1);
    rd_chk("tmo.forced_clr", 3'd7, 32'h0);
`else
    repeat (1000) tick();
    check("tmo.no_pulse", n_pulses, base);
    check("tmo.vlan_old", encaps_vlan_o, a_vlan);
    rd_chk("tmo.still_pending", 3'd7, 32'h1);
    rx_idle_i = 1'b1;
    tick();
    tick();
    model_apply();
    check("tmo.late_cfg", cfg_update_o, 1'b1);
    check("tmo.late_vlan", encaps_vlan_o, 12'habc);
`endif

    // FLAGS written during APPLY miss it; commit during APPLY re-enters PEND.
    rx_idle_i = 1'b1;
    wr(3'd7, 32'h1, 4'h1);
    tick();
    model_apply();
    wr(3'd6, 32'h3, 4'h1);
    check("apply.cfg1", cfg_update_o, 1'b1);
    check("apply.promisc_excl", promisc_mode_o, 1'b0);
    check_actives("apply1");
    rd_chk("apply.flags_shadow", 3'd6, 32'h3);
    wr(3'd7, 32'h1, 4'h1);
    tick();
    model_apply();
    wr(3'd7, 32'h1, 4'h1);
    check("apply.cfg2", cfg_update_o, 1'b1);
    check("apply.promisc", promisc_mode_o, 1'b1);
    check("apply.alt_en", also_use_alt_host_mac_o, 1'b1);
    rx_idle_i = 1'b0;
    wr(3'd4, 32'h00000123, 4'h3);
    rd_chk("apply.repend", 3'd7, 32'h1);
    rx_idle_i = 1'b1;
    tick();
    model_apply();
    check("apply.cfg3_off", cfg_update_o, 1'b0);
    tick();
    check("apply.cfg3", cfg_update_o, 1'b1);
    check("apply.vlan_pend", encaps_vlan_o, 12'h123);
    check_actives("apply3");

    // Randomized writes (with coincident reads) and commits against the model.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 3; k++) begin
        a  = 3'($urandom_range(6, 0));
        d  = $urandom;
        if (a == 3'd5 && $urandom_range(1, 0) == 1) d = $urandom_range(9600, 68);
        be = 4'($urandom_range(15, 0));
        exp32 = model_read(a);
        bus(a, 1'b1, d, be, 1'b1, r, v);
        check("rand.rvalid", v, 1'b1);
        check("rand.pre_write_rd", r, exp32);
      end
      wr(3'd7, 32'h1, 4'h1);
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (cfg_update_o) seen = 1'b1;
      end
      check("rand.apply_seen", seen, 1'b1);
      model_apply();
      check_actives("rand");
    end
    for (int k = 0; k < 7; k++) begin
      rd_chk("final.shadow", 3'(k), model_read(3'(k)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
